// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle RISC-V branch-condition unit.
//
// Evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU by walking the captured operands one
// byte per cycle, most significant byte first, through a single shared 8-bit
// magnitude comparator. Handshaked request/response interfaces.
//
// Build option:
//   CMP_EARLY_EXIT_EN - when defined, the compare phase ends on the first
//                       unequal byte instead of always walking all N bytes.
//                       Results are identical; only latency differs.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request ready (idle and not in reset)
//   a_i, b_i     operands rs1 / rs2, captured on accept
//   funct3_i     branch funct3, captured on accept
//   rsp_valid_o  result valid
//   rsp_ready_i  result consumed
//   taken_o      branch condition true
//   eq_o         a == b
//   lt_o         a < b (signed for BLT/BGE, unsigned otherwise)
//   err_o        funct3 is not a branch encoding (010/011)

module branch_cmp_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       funct3_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             taken_o,
    output logic             eq_o,
    output logic             lt_o,
    output logic             err_o
);

    localparam int unsigned N    = WIDTH / 8;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2:0]        funct3_q;
    logic [IdxW-1:0]   idx_q;
    logic              decided_q;
    logic              lt_acc_q;
    logic              taken_q;
    logic              eq_q;
    logic              lt_q;
    logic              err_q;

    // Byte-slice comparator and next-state helpers
    logic [7:0] byte_a;
    logic [7:0] byte_b;
    logic       is_signed;
    logic       msb_byte;
    logic       byte_eq;
    logic       byte_blt;
    logic       decided_d;
    logic       lt_d;
    logic       last_byte;
    logic       cmp_finish;
    logic       illegal_f3;

    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:         t = eq;
            3'b001:         t = ~eq;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = ~lt;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    always_comb begin
        byte_a = 8'h00;
        byte_b = 8'h00;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) begin
                byte_a = a_q[i*8 +: 8];
                byte_b = b_q[i*8 +: 8];
            end
        end

        is_signed = (funct3_q == 3'b100) || (funct3_q == 3'b101);
        msb_byte  = (idx_q == IdxW'(N - 1));

        // Flipping the sign bit of the top byte turns a two's-complement
        // compare into an unsigned one, so the one slice serves both.
        if (is_signed && msb_byte) begin
            byte_a[7] = ~byte_a[7];
            byte_b[7] = ~byte_b[7];
        end

        byte_eq  = (byte_a == byte_b);
        byte_blt = (byte_a < byte_b);

        // The first differing byte decides; later bytes cannot override it.
        decided_d = decided_q | ~byte_eq;
        lt_d      = decided_q ? lt_acc_q : (~byte_eq & byte_blt);

        last_byte = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
        cmp_finish = last_byte | ~byte_eq;
`else
        cmp_finish = last_byte;
`endif

        illegal_f3 = (funct3_i[2:1] == 2'b01);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            funct3_q  <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_acc_q  <= 1'b0;
            taken_q   <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        a_q       <= a_i;
                        b_q       <= b_i;
                        funct3_q  <= funct3_i;
                        idx_q     <= IdxW'(N - 1);
                        decided_q <= 1'b0;
                        lt_acc_q  <= 1'b0;
                        if (illegal_f3) begin
                            state_q <= StDone;
                            err_q   <= 1'b1;
                            taken_q <= 1'b0;
                            eq_q    <= 1'b0;
                            lt_q    <= 1'b0;
                        end else begin
                            state_q <= StCmp;
                        end
                    end
                end

                StCmp: begin
                    decided_q <= decided_d;
                    lt_acc_q  <= lt_d;
                    idx_q     <= idx_q - IdxW'(1);
                    if (cmp_finish) begin
                        state_q <= StDone;
                        eq_q    <= ~decided_d;
                        lt_q    <= lt_d;
                        taken_q <= branch_taken(funct3_q, ~decided_d, lt_d);
                        err_q   <= 1'b0;
                    end
                end

                StDone: begin
                    // Results stay frozen until the consumer takes them.
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                        taken_q <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle) & rst_ni;
    assign rsp_valid_o = (state_q == StDone);
    assign taken_o     = taken_q;
    assign eq_o        = eq_q;
    assign lt_o        = lt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Scoreboard bench for branch_cmp_seq: the driver pushes hand-computed
// expected responses (including latency in cycles from accept) and a
// negedge monitor compares every cycle the DUT holds rsp_valid_o.

module tb_branch_cmp_seq;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        taken;
    logic        eq;
    logic        lt;
    logic        err;

    typedef struct {
        logic taken;
        logic eq;
        logic lt;
        logic err;
        int   lat;
        int   acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   first  = 1'b1;

    branch_cmp_seq #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .a_i        (a),
        .b_i        (b),
        .funct3_i   (f3),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .taken_o    (taken),
        .eq_o       (eq),
        .lt_o       (lt),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] if3,
                         input logic et, input logic ee, input logic el, input logic er,
                         input int lat, input bit expect_rsp);
        exp_t e;
        req_valid = 1'b1;
        a         = ia;
        b         = ib;
        f3        = if3;
        chk("req_ready_before_accept", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (expect_rsp) begin
            e.taken = et;
            e.eq    = ee;
            e.lt    = el;
            e.err   = er;
            e.lat   = lat;
            e.acc   = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            first = 1'b1;
        end else if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)",
                         $time);
            end else begin
                e = q[0];
                if (first) chk("latency", cyc - e.acc + 1, e.lat);
                first = 1'b0;
                chk("taken", int'(taken), int'(e.taken));
                chk("eq", int'(eq), int'(e.eq));
                chk("lt", int'(lt), int'(e.lt));
                chk("err", int'(err), int'(e.err));
                if (rsp_ready) begin
                    void'(q.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        a         = '0;
        b         = '0;
        f3        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_outputs", int'({taken, eq, lt, err}), 0);
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_reset", int'(req_ready), 1);

        // 1: BEQ equal
        issue(32'h12345678, 32'h12345678, 3'b000, 1, 1, 0, 0, 5, 1);
        wait_drain("drain_beq");
        // 2: BLT -1 < 1 signed; BLTU 0xFFFFFFFF > 1
        issue(32'hFFFFFFFF, 32'h00000001, 3'b100, 1, 0, 1, 0, Early ? 2 : 5, 1);
        wait_drain("drain_blt");
        issue(32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 0, 0, 0, Early ? 2 : 5, 1);
        wait_drain("drain_bltu");
        // 3: BGE, difference in byte k=2
        issue(32'h00000100, 32'h000000FF, 3'b101, 1, 0, 0, 0, Early ? 4 : 5, 1);
        wait_drain("drain_bge");
        // Sign-bit handling on the MSB byte
        issue(32'h80000000, 32'h7FFFFFFF, 3'b111, 1, 0, 0, 0, Early ? 2 : 5, 1);
        wait_drain("drain_bgeu");
        issue(32'h80000000, 32'h7FFFFFFF, 3'b100, 1, 0, 1, 0, Early ? 2 : 5, 1);
        wait_drain("drain_blt_neg");
        // 4: illegal encodings, then BNE 1 vs 2 (differs in last byte)
        issue(32'hDEADBEEF, 32'hDEADBEEF, 3'b010, 0, 0, 0, 1, 1, 1);
        wait_drain("drain_ill010");
        issue(32'h00000000, 32'h00000005, 3'b011, 0, 0, 0, 1, 1, 1);
        wait_drain("drain_ill011");
        issue(32'h00000001, 32'h00000002, 3'b001, 1, 0, 1, 0, 5, 1);
        wait_drain("drain_bne");

        // 5: back-pressure with ignored requests
        rsp_ready = 1'b0;
        issue(32'h0, 32'h0, 3'b001, 0, 1, 0, 0, 5, 1);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("t5_rsp_seen", int'(rsp_valid), 1);
        for (int i = 0; i < 3; i++) begin
            req_valid = (i != 1);
            a         = 32'h0000FFFF;
            b         = 32'h00000000;
            f3        = 3'b000;
            chk("t5_req_ready_busy", int'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_req_ready_release", int'(req_ready), 1);
        chk("t5_rsp_valid_release", int'(rsp_valid), 0);
        chk("t5_queue_empty", q.size(), 0);

        // 6: reset in the middle of a compare drops the op
        issue(32'h00000001, 32'h80000000, 3'b110, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rsp_valid", int'(rsp_valid), 0);
        chk("t6_outputs", int'({taken, eq, lt, err}), 0);
        chk("t6_req_ready_in_reset", int'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_req_ready_after", int'(req_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_rsp", int'(rsp_valid), 0);
        issue(32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000, 1, 1, 0, 0, 5, 1);
        wait_drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_cmp_seq.md
Name: branch_cmp_seq

Overview:
Multi-cycle branch-condition unit that evaluates RISC-V branch conditions using one shared 8-bit magnitude comparator slice. It walks the operands one byte per cycle, MSB byte first. It sits between decode/issue and the branch-resolution logic, with valid/ready handshakes on request and response. Area-optimised alternative to a full-width comparator.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8; N = WIDTH/8 byte steps.

Ports:
clk_i  input  1  clock; single clock domain
rst_ni  input  1  reset, synchronous, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  request ready; = (state==IDLE) & rst_ni
a_i  input  WIDTH  operand rs1; sampled on accept
b_i  input  WIDTH  operand rs2; sampled on accept
funct3_i  input  3  branch funct3; sampled on accept
rsp_valid_o  output  1  result valid
rsp_ready_i  input  1  result consumed
taken_o  output  1  branch condition true
eq_o  output  1  a == b
lt_o  output  1  a < b (signed for BLT/BGE, unsigned otherwise)
err_o  output  1  funct3 not a branch encoding (010, 011)

Behaviour:
- One clock. Reset is synchronous, active-low; the clock port is clk_i and the reset port is rst_ni.
- Reset (rst_ni low at a clk_i edge): state=IDLE. rsp_valid_o, taken_o, eq_o, lt_o and err_o are 0. Byte index and sticky flags are cleared. req_ready_o is 0 while rst_ni is low.
- FSM states: IDLE, CMP, DONE.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o (cycle T0):
  - capture a_i, b_i and funct3_i; set idx=N-1.
  - legal funct3 goes to CMP; 010/011 goes to DONE with err_o=1 and taken_o=eq_o=lt_o=0.
- CMP, one byte per cycle:
  - compare byte idx of the captured a and b through the 8-bit comparator (equal / a-larger / b-larger).
  - for signed ops (BLT 100, BGE 101), bit 7 of the MSB byte of both operands is inverted before the compare. All other bytes and all unsigned ops compare raw.
  - the first unequal byte latches decided=1 and lt = b-larger. Later bytes never overwrite it.
  - idx decrements each cycle. After idx==0 is processed, go to DONE.
  - if no byte differed: eq=1, lt=0.
- DONE: rsp_valid_o=1. taken_o per funct3:
  - BEQ 000 = eq; BNE 001 = !eq
  - BLT 100 = lt; BGE 101 = !lt
  - BLTU 110 = lt; BGEU 111 = !lt
- Results are registered and held stable while rsp_valid_o & !rsp_ready_i.
- rsp_ready_i high in DONE returns to IDLE next cycle. No same-cycle re-accept, because req_ready_o=0 in DONE.
- Latency, feature off: rsp_valid_o rises at T(N+1). Throughput is one op per N+2 cycles minimum.
- Illegal funct3: rsp_valid_o at T1.
- req_valid_i outside IDLE is ignored; operands are not re-sampled.
- Reset mid-CMP or mid-DONE: the in-flight op is dropped silently and no response is produced.

Optional Feature:
CMP_EARLY_EXIT_EN.
- Defined: in CMP, the first unequal byte sets lt and goes directly to DONE. rsp_valid_o rises the cycle after that byte is processed (byte k, counted from MSB as k=0, gives T(k+2)). All-equal operands still take T(N+1).
- Undefined: every legal op takes exactly N CMP cycles (fixed latency). Results are identical in both builds; only timing differs.

Test Plan:
1. BEQ, a=0x12345678, b=0x12345678 -> eq_o=1, taken_o=1, lt_o=0, rsp_valid_o at T5 (both builds).
2. BLT, a=0xFFFFFFFF, b=0x00000001 -> lt_o=1, taken_o=1. Repeat as BLTU -> lt_o=0, taken_o=0. rsp at T2 with CMP_EARLY_EXIT_EN, T5 without.
3. BGE, a=0x00000100, b=0x000000FF -> lt_o=0, eq_o=0, taken_o=1. rsp at T4 early-exit, T5 otherwise.
4. funct3=010, any operands -> err_o=1, taken_o=0, rsp_valid_o at T1. Next request with funct3=001, a=1, b=2 -> err_o=0, taken_o=1.
5. BNE, a=0, b=0, rsp_ready_i held low 3 cycles after rsp_valid_o -> outputs stable (taken_o=0), req_ready_o=0, req_valid_i pulses ignored. Release -> IDLE and req_ready_o=1 next cycle.
6. Start BLTU a=0x00000001, b=0x80000000, assert rst_ni low at T2 -> next edge rsp_valid_o=0 and all outputs 0. No response for the dropped op. After release, BEQ a=b=0xA5A5A5A5 -> taken_o=1 with nominal latency.
